// File: rtl/ifetch_buffer.sv
// Fetch stage: issues word reads to a 1-cycle synchronous instruction memory and
// queues {instr, pc, misalign} for decode. Define IFETCH_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module ifetch_buffer #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       fetch_pc,
  input  logic              fetch_req,
  output logic              fetch_ready,
  input  logic              flush,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic              out_misalign
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        mis;
  } entry_t;

  entry_t             fifo_mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               inflight;
  logic [31:0]        inflight_pc;
  logic               inflight_mis;

  logic               req_mis;
  logic               accept;
  logic [CNT_W:0]     credit;
  logic               fifo_empty;
  logic               bypass_valid;
  logic               bypass_take;
  logic               push;
  logic               pop;
  entry_t             resp;
  entry_t             head;
  entry_t             out_entry;

  // Credit counts the in-flight slot so a returning response always has room.
  assign credit      = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign fetch_ready = !flush && (credit < (CNT_W+1)'(DEPTH));
  assign req_mis     = (fetch_pc[1:0] != 2'b00);
  assign accept      = fetch_req && fetch_ready;
  assign imem_en     = accept && !req_mis;
  assign imem_addr   = imem_en ? fetch_pc[ADDR_W+1:2] : '0;

  // Misaligned fetches never touch memory and return a zero instruction.
  assign resp.instr  = inflight_mis ? 32'h0 : imem_rdata;
  assign resp.pc     = inflight_pc;
  assign resp.mis    = inflight_mis;

  assign fifo_empty  = (count == '0);
  assign head        = fifo_mem[rd_ptr];

`ifdef IFETCH_BYPASS_EN
  assign bypass_valid = fifo_empty && inflight && !flush;
`else
  assign bypass_valid = 1'b0;
`endif

  assign bypass_take = bypass_valid && out_ready;
  assign pop         = !fifo_empty && out_ready && !flush;
  assign push        = inflight && !flush && !bypass_take;

  always_comb begin
    out_entry = '0;
    if (!fifo_empty) begin
      out_entry = head;
    end else if (bypass_valid) begin
      out_entry = resp;
    end
  end

  assign out_valid    = !fifo_empty || bypass_valid;
  assign out_instr    = out_entry.instr;
  assign out_pc       = out_entry.pc;
  assign out_misalign = out_entry.mis;

  // Control state; flush outranks push, pop and accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      count        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      inflight     <= 1'b0;
      inflight_pc  <= '0;
      inflight_mis <= 1'b0;
    end else if (flush) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= accept;
      if (accept) begin
        inflight_pc  <= fetch_pc;
        inflight_mis <= req_mis;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fifo_mem[wr_ptr] <= resp;
    end
  end

endmodule

// File: tb/tb_ifetch_buffer.sv
// Scoreboard bench for ifetch_buffer: accepted fetches push expected entries,
// a monitor pops and compares whenever decode consumes an output.
module tb_ifetch_buffer;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 2;
`ifdef IFETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [31:0]       fetch_pc = '0;
  logic              fetch_req = 1'b0;
  logic              fetch_ready;
  logic              flush = 1'b0;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_instr;
  logic [31:0]       out_pc;
  logic              out_misalign;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  ifetch_buffer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_pc    (fetch_pc),
    .fetch_req   (fetch_req),
    .fetch_ready (fetch_ready),
    .flush       (flush),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_misalign(out_misalign)
  );

  always #5 clk = ~clk;

  // Memory word n holds 0x1000_0000 + n.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= 32'h1000_0000 + 32'(imem_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.mis   = (pc[1:0] != 2'b00);
    e.instr = e.mis ? 32'h0 : (32'h1000_0000 + {22'b0, pc[11:2]});
    return e;
  endfunction

  // Stimulus side of the scoreboard: record every accepted fetch.
  always @(negedge clk) begin
    if (!reset && !flush && fetch_req && fetch_ready) sb.push_back(model(fetch_pc));
  end

  // Monitor: compare each consumed output against the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", out_pc, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("out_pc", out_pc, e.pc);
          check("out_instr", out_instr, e.instr);
          check("out_misalign", 32'(out_misalign), 32'(e.mis));
        end
      end
      if (!out_valid) check("idle_zero", out_pc | out_instr | 32'(out_misalign), 32'h0);
      check("outstanding_le_depth", 32'(sb.size() > DEPTH), 32'h0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold fetch_req with pc until it is accepted; leaves fetch_req asserted.
  task automatic fetch_one(input logic [31:0] pc);
    int n;
    fetch_pc  = pc;
    fetch_req = 1'b1;
    n = 0;
    while (!fetch_ready && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) check("fetch_timeout", 32'(n), 32'h0);
    step();
  endtask

  task automatic drain();
    int n;
    fetch_req = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 50) begin
      step();
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'h0);
  endtask

  initial begin
    int lat;
    int accepts;
    logic [31:0] pc;

    // Reset held for two cycles.
    step();
    step();
    reset = 1'b0;
    step();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_fetch_ready", 32'(fetch_ready), 32'h1);
    check("rst_imem_en", 32'(imem_en), 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);

    // Single fetch: memory address and first-valid latency.
    out_ready = 1'b1;
    fetch_pc  = 32'h8;
    fetch_req = 1'b1;
    #1;
    check("imem_en_aligned", 32'(imem_en), 32'h1);
    check("imem_addr", 32'(imem_addr), 32'h2);
    step();
    fetch_req = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    check("first_valid_latency", 32'(lat), 32'(LAT));
    drain();

    // Back-to-back fetches 0x0, 0x4, 0x8.
    fetch_one(32'h0);
    fetch_one(32'h4);
    fetch_one(32'h8);
    drain();

    // Backpressure: exactly DEPTH accepts, then stall.
    out_ready = 1'b0;
    fetch_req = 1'b1;
    pc = 32'h20;
    accepts = 0;
    for (int i = 0; i < 6; i++) begin
      fetch_pc = pc;
      if (fetch_ready) begin
        accepts++;
        pc = pc + 32'h4;
      end
      step();
    end
    check("bp_accepts", 32'(accepts), 32'(DEPTH));
    check("bp_fetch_ready", 32'(fetch_ready), 32'h0);
    drain();
    check("bp_ready_again", 32'(fetch_ready), 32'h1);

    // Misaligned fetch never reads memory.
    fetch_pc  = 32'h6;
    fetch_req = 1'b1;
    #1;
    check("imem_en_misaligned", 32'(imem_en), 32'h0);
    step();
    drain();

    // Flush drops the in-flight 0x10; 0x40 follows.
    fetch_one(32'h10);
    fetch_req = 1'b0;
    flush = 1'b1;
    #1;
    check("flush_fetch_ready", 32'(fetch_ready), 32'h0);
    step();
    flush = 1'b0;
    fetch_one(32'h40);
    drain();

    // Reset with two queued entries.
    out_ready = 1'b0;
    fetch_one(32'h80);
    fetch_one(32'h84);
    fetch_req = 1'b0;
    step();
    step();
    check("queued_valid", 32'(out_valid), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    check("midrst_fetch_ready", 32'(fetch_ready), 32'h1);
    step();
    check("midrst_still_empty", 32'(out_valid), 32'h0);

    // Random push/pop mix around a full FIFO.
    pc = 32'h100;
    for (int i = 0; i < 20; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      fetch_req = 1'($urandom_range(0, 1));
      fetch_pc  = pc;
      if (fetch_req && fetch_ready) pc = pc + 32'h4;
      step();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
